wfg_stim_pat: RTL and testbench
===============================

Name: wfg_stim_pat

Overview:
- AXI-Stream master stimulus source feeding the pattern driver stage (wfg_drive_pat) with 32-bit pattern words.
- Generates constant, incrementing, walking-bit or LFSR sequences, framed by tlast every N words.
- Configuration arrives as static inputs from a separate wishbone register block.
- Sits in the core clock domain between the register block and the pattern driver's AXI-Stream slave.

Parameters:
- AXIS_DATA_WIDTH, 32, stream word width; the LFSR and walking-bit modes require exactly 32.
- LEN_W, 16, width of the frame length and frame counter.

Ports:
- clk  input  1  core clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- ctrl_en_i  input  1  generator enable (level).
- cfg_mode_i  input  2  0=constant, 1=increment, 2=walking rotate-left, 3=LFSR.
- cfg_seed_i  input  AXIS_DATA_WIDTH  first word of the sequence.
- cfg_inc_i  input  AXIS_DATA_WIDTH  increment step for mode 1.
- cfg_len_i  input  LEN_W  words per frame minus 1.
- wfg_axis_tready_i  input  1  downstream ready.
- wfg_axis_tvalid_o  output  1  word valid.
- wfg_axis_tlast_o  output  1  last word of frame.
- wfg_axis_tdata_o  output  AXIS_DATA_WIDTH  pattern word.
- active_o  output  1  high in RUN or DRAIN.
- frame_cnt_o  output  LEN_W  completed frames, wraps modulo 2^LEN_W.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE.
  - tvalid=0, tlast=0, tdata=0, active_o=0, frame_cnt_o=0, word counter=0.
  - Reset overrides everything, including a pending unaccepted word; tvalid drops after that edge.
- FSM states: IDLE, RUN, DRAIN.
- IDLE + ctrl_en_i=1 at edge:
  - Latch mode, inc and len into shadow registers.
  - tdata <= seed; in mode 3, a seed of 0 is replaced by 1.
  - tvalid <= 1, tlast <= (len==0), word counter <= 0, state -> RUN.
  - Latency: first word is visible 1 cycle after enable is sampled.
- Config inputs are ignored outside the IDLE->RUN transition; they are re-latched only after a return to IDLE.
- Handshake = tvalid & tready at an edge. In RUN, on handshake:
  - tdata <= next(tdata); tvalid stays 1, giving full throughput of one word per cycle.
  - If tlast was 1: word counter <= 0, frame_cnt_o += 1, tlast <= (len==0).
  - Otherwise: word counter += 1, tlast <= (counter+1 == len).
- next() per mode:
  - Mode 0: unchanged.
  - Mode 1: tdata + inc, modulo 2^32, no saturation.
  - Mode 2: rotate left by 1.
  - Mode 3: Galois right shift, (d>>1) ^ (d[0] ? 32'h8020_0003 : 0).
- Data continues across frame boundaries; the seed is not reloaded per frame.
- No handshake: tdata, tvalid and tlast hold stable (AXI-Stream rule).
- RUN + ctrl_en_i=0:
  - With handshake in the same edge: word accepted, counters update as above, tvalid <= 0, tlast <= 0, state -> IDLE.
  - Without handshake: state -> DRAIN; the word is held.
- DRAIN:
  - On handshake: frame counter updates if tlast, tvalid <= 0, tlast <= 0, state -> IDLE.
  - ctrl_en_i re-asserted during DRAIN is ignored until IDLE is reached.
- tvalid never drops without a handshake, except on reset.
- tdata keeps its last value in IDLE. A new enable restarts from the seed; frame_cnt_o is not cleared, the word counter is.
- active_o = (state != IDLE), registered with the state.
- Frame counter wraps 0xFFFF -> 0x0000 silently.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles with tready=1, then release with en=0 -> tvalid=0, tdata=0, frame_cnt=0, active=0 for 10 cycles.
- Increment framing:
  - Stimulus: mode=1, seed=0x10, inc=4, len=2, tready=1.
  - Required: tdata 0x10, 0x14, 0x18, 0x1C, 0x20, 0x24 on consecutive cycles.
  - Required: tlast on 0x18 and 0x24; frame_cnt reaches 2; first valid 1 cycle after en.
- Backpressure:
  - Stimulus: mode=2, seed=0x8000_0001, tready toggling 1,0,0,1.
  - Required: words 0x8000_0001, 0x0000_0003, 0x0000_0006, each held stable while tready=0, none skipped or duplicated.
- LFSR: mode=3, seed=0 -> words 0x0000_0001, 0x8020_0003, 0xC030_0002.
- Disable during stall:
  - Stimulus: tready=0, drop en.
  - Required: state DRAIN, tvalid stays 1 with the same data; raise tready -> one handshake, then tvalid=0 and active=0.
  - Then: re-enable -> restart at the seed with tlast alignment reset.
- Reset mid-frame: assert rst_n=0 with tvalid=1, tready=0 -> tvalid=0, frame_cnt=0 after the edge.
- Len=0: every word carries tlast; frame_cnt increments each handshake and wraps 0xFFFF -> 0.

Source files
------------

// File: rtl/wfg_stim_pat.sv
// AXI-Stream pattern source for the pattern driver stage.
// Emits constant, incrementing, walking-bit or LFSR words and frames them
// with tlast every (cfg_len_i + 1) words. Configuration is sampled only on
// the IDLE -> RUN transition; a disable waits for the held word to drain.
module wfg_stim_pat #(
  // The walking-bit and LFSR modes are defined for 32-bit words only.
  parameter int unsigned AXIS_DATA_WIDTH = 32,
  parameter int unsigned LEN_W           = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ctrl_en_i,
  input  logic [1:0]                 cfg_mode_i,
  input  logic [AXIS_DATA_WIDTH-1:0] cfg_seed_i,
  input  logic [AXIS_DATA_WIDTH-1:0] cfg_inc_i,
  input  logic [LEN_W-1:0]           cfg_len_i,
  input  logic                       wfg_axis_tready_i,
  output logic                       wfg_axis_tvalid_o,
  output logic                       wfg_axis_tlast_o,
  output logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o,
  output logic                       active_o,
  output logic [LEN_W-1:0]           frame_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_INC   = 2'd1;
  localparam logic [1:0] MODE_WALK  = 2'd2;
  localparam logic [1:0] MODE_LFSR  = 2'd3;

  // Galois feedback taps for the right-shifting LFSR.
  localparam logic [AXIS_DATA_WIDTH-1:0] LFSR_TAPS = AXIS_DATA_WIDTH'(32'h8020_0003);

  state_e                     state_q;
  logic [1:0]                 mode_q;
  logic [AXIS_DATA_WIDTH-1:0] inc_q;
  logic [LEN_W-1:0]           len_q;
  logic [LEN_W-1:0]           word_cnt_q;
  logic [LEN_W-1:0]           frame_cnt_q;
  logic [AXIS_DATA_WIDTH-1:0] tdata_q;
  logic                       tvalid_q;
  logic                       tlast_q;
  logic                       active_q;

  logic [AXIS_DATA_WIDTH-1:0] tdata_d;
  logic [AXIS_DATA_WIDTH-1:0] seed_d;
  logic [LEN_W-1:0]           word_cnt_inc;
  logic                       handshake;

  assign handshake    = tvalid_q & wfg_axis_tready_i;
  assign word_cnt_inc = word_cnt_q + LEN_W'(1);

  // Next pattern word from the current one, and the (LFSR-safe) start word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    tdata_d = tdata_q;
    seed_d  = cfg_seed_i;
    unique case (mode_q)
      MODE_CONST: tdata_d = tdata_q;
      MODE_INC:   tdata_d = tdata_q + inc_q;
      MODE_WALK:  tdata_d = {tdata_q[AXIS_DATA_WIDTH-2:0], tdata_q[AXIS_DATA_WIDTH-1]};
      MODE_LFSR:  tdata_d = (tdata_q >> 1) ^ (tdata_q[0] ? LFSR_TAPS : '0);
      default:    tdata_d = tdata_q;
    endcase
    // An all-zero LFSR state would lock up, so a zero seed starts at 1.
    if (cfg_mode_i == MODE_LFSR && cfg_seed_i == '0) begin
      seed_d = AXIS_DATA_WIDTH'(1);
    end
  end

  // Control FSM with registered stream outputs, counters and config shadows.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_CONST;
      inc_q       <= '0;
      len_q       <= '0;
      word_cnt_q  <= '0;
      frame_cnt_q <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ctrl_en_i) begin
            mode_q     <= cfg_mode_i;
            inc_q      <= cfg_inc_i;
            len_q      <= cfg_len_i;
            tdata_q    <= seed_d;
            tvalid_q   <= 1'b1;
            tlast_q    <= (cfg_len_i == '0);
            word_cnt_q <= '0;
            state_q    <= ST_RUN;
            active_q   <= 1'b1;
          end
        end

        ST_RUN: begin
          if (handshake) begin
            if (tlast_q) begin
              word_cnt_q  <= '0;
              frame_cnt_q <= frame_cnt_q + LEN_W'(1);
            end else begin
              word_cnt_q  <= word_cnt_inc;
            end
            if (ctrl_en_i) begin
              tdata_q <= tdata_d;
              tlast_q <= tlast_q ? (len_q == '0) : (word_cnt_inc == len_q);
            end else begin
              // Accepted word was the last one; the data register keeps it.
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              state_q  <= ST_IDLE;
              active_q <= 1'b0;
            end
          end else if (!ctrl_en_i) begin
            // Pending word must still be delivered before going idle.
            state_q <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (handshake) begin
            if (tlast_q) begin
              frame_cnt_q <= frame_cnt_q + LEN_W'(1);
            end
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
          end
        end

        default: begin
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
          state_q  <= ST_IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign wfg_axis_tvalid_o = tvalid_q;
  assign wfg_axis_tlast_o  = tlast_q;
  assign wfg_axis_tdata_o  = tdata_q;
  assign active_o          = active_q;
  assign frame_cnt_o       = frame_cnt_q;

endmodule

// File: tb/tb_wfg_stim_pat.sv
// Scoreboard bench for wfg_stim_pat: directed sequences push expected words,
// a negedge monitor pops them on each handshake and checks held words on stalls.
module tb_wfg_stim_pat;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;

  logic          clk;
  logic          rst_n;
  logic          ctrl_en;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_seed;
  logic [DW-1:0] cfg_inc;
  logic [LW-1:0] cfg_len;
  logic          tready;
  logic          tvalid;
  logic          tlast;
  logic [DW-1:0] tdata;
  logic          active;
  logic [LW-1:0] frame_cnt;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  word_t sb_q[$];
  bit    sb_on;
  int    n_tests;
  int    n_fail;

  wfg_stim_pat #(
    .AXIS_DATA_WIDTH(DW),
    .LEN_W          (LW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ctrl_en_i        (ctrl_en),
    .cfg_mode_i       (cfg_mode),
    .cfg_seed_i       (cfg_seed),
    .cfg_inc_i        (cfg_inc),
    .cfg_len_i        (cfg_len),
    .wfg_axis_tready_i(tready),
    .wfg_axis_tvalid_o(tvalid),
    .wfg_axis_tlast_o (tlast),
    .wfg_axis_tdata_o (tdata),
    .active_o         (active),
    .frame_cnt_o      (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [DW-1:0] d, input logic l);
    word_t w;
    w.data = d;
    w.last = l;
    sb_q.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enable, stream n words with tready=1, and drop enable so the n-th
  // handshake coincides with the disable.
  task automatic run_words(input int n);
    ctrl_en = 1'b1;
    tick();
    check("first_valid_latency", {31'b0, tvalid}, 32'd1);
    repeat (n - 1) tick();
    ctrl_en = 1'b0;
    tick();
    check("idle_after_run_tvalid", {31'b0, tvalid}, 32'd0);
    check("idle_after_run_active", {31'b0, active}, 32'd0);
  endtask

  // Monitor: inputs change just after posedge, so the negedge view equals
  // what the next rising edge will see.
  always @(negedge clk) begin
    if (rst_n && sb_on && tvalid) begin
      if (tready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%08h expected none", tdata);
        end else begin
          word_t w;
          w = sb_q.pop_front();
          check("sb_data", tdata, w.data);
          check("sb_last", {31'b0, tlast}, {31'b0, w.last});
        end
      end else if (sb_q.size() != 0) begin
        check("hold_data", tdata, sb_q[0].data);
      end
    end
  end

  initial begin
    #950_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rdy_pat;
    bit         wrapped;
    n_tests  = 0;
    n_fail   = 0;
    sb_on    = 1'b1;
    rst_n    = 1'b0;
    ctrl_en  = 1'b0;
    cfg_mode = 2'd0;
    cfg_seed = '0;
    cfg_inc  = '0;
    cfg_len  = '0;
    tready   = 1'b1;

    // Reset and idle.
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_tvalid", {31'b0, tvalid}, 32'd0);
      check("rst_tdata", tdata, 32'd0);
      check("rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
      check("rst_active", {31'b0, active}, 32'd0);
    end

    // Incrementing words, two frames of three.
    cfg_mode = 2'd1; cfg_seed = 32'h10; cfg_inc = 32'd4; cfg_len = 16'd2;
    check("pre_enable_tvalid", {31'b0, tvalid}, 32'd0);
    expect_word(32'h10, 1'b0); expect_word(32'h14, 1'b0); expect_word(32'h18, 1'b1);
    expect_word(32'h1C, 1'b0); expect_word(32'h20, 1'b0); expect_word(32'h24, 1'b1);
    run_words(6);
    check("inc_frame_cnt", {16'b0, frame_cnt}, 32'd2);
    check("inc_sb_empty", sb_q.size(), 32'd0);

    // Walking bit under a 1,0,0,1 tready pattern, then disable while stalled.
    cfg_mode = 2'd2; cfg_seed = 32'h8000_0001; cfg_len = 16'd7;
    tready = 1'b0;
    expect_word(32'h8000_0001, 1'b0); expect_word(32'h0000_0003, 1'b0);
    expect_word(32'h0000_0006, 1'b0); expect_word(32'h0000_000C, 1'b0);
    ctrl_en = 1'b1;
    tick();
    rdy_pat = 4'b1001;
    for (int i = 0; i < 40; i++) begin
      if (sb_q.size() <= 1) break;
      tready = rdy_pat[3 - (i % 4)];
      tick();
    end
    check("bp_popped_three", sb_q.size(), 32'd1);
    ctrl_en = 1'b0;
    tready  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_tvalid", {31'b0, tvalid}, 32'd1);
      check("drain_active", {31'b0, active}, 32'd1);
      check("drain_tdata", tdata, 32'h0000_000C);
    end
    ctrl_en = 1'b1;  // ignored while draining
    tick();
    check("drain_ignores_en", {31'b0, active}, 32'd1);
    ctrl_en = 1'b0;
    tready  = 1'b1;
    tick();
    check("drain_done_tvalid", {31'b0, tvalid}, 32'd0);
    check("drain_done_active", {31'b0, active}, 32'd0);
    check("drain_sb_empty", sb_q.size(), 32'd0);
    check("drain_frame_cnt", {16'b0, frame_cnt}, 32'd2);

    // Restart aligns tlast from the seed again after a mid-frame stop.
    cfg_mode = 2'd1; cfg_seed = 32'h100; cfg_inc = 32'd1; cfg_len = 16'd1;
    expect_word(32'h100, 1'b0);
    run_words(1);
    expect_word(32'h100, 1'b0); expect_word(32'h101, 1'b1); expect_word(32'h102, 1'b0);
    run_words(3);
    check("restart_frame_cnt", {16'b0, frame_cnt}, 32'd3);

    // LFSR with zero seed.
    cfg_mode = 2'd3; cfg_seed = 32'h0; cfg_len = 16'd7;
    expect_word(32'h0000_0001, 1'b0); expect_word(32'h8020_0003, 1'b0);
    expect_word(32'hC030_0002, 1'b0);
    run_words(3);
    check("lfsr_sb_empty", sb_q.size(), 32'd0);

    // Reset while a word is pending.
    cfg_mode = 2'd0; cfg_seed = 32'hAA;
    tready  = 1'b0;
    ctrl_en = 1'b1;
    tick();
    check("pend_tvalid", {31'b0, tvalid}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("midrst_tvalid", {31'b0, tvalid}, 32'd0);
    check("midrst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
    check("midrst_active", {31'b0, active}, 32'd0);
    ctrl_en = 1'b0;
    rst_n   = 1'b1;
    tready  = 1'b1;
    tick();

    // Len = 0: every word is last; then run the frame counter through its wrap.
    cfg_mode = 2'd0; cfg_seed = 32'h5A; cfg_len = 16'd0;
    expect_word(32'h5A, 1'b1); expect_word(32'h5A, 1'b1); expect_word(32'h5A, 1'b1);
    run_words(3);
    check("len0_frame_cnt", {16'b0, frame_cnt}, 32'd3);
    sb_on   = 1'b0;
    ctrl_en = 1'b1;
    wrapped = 1'b0;
    tick();
    for (int i = 0; i < 70000; i++) begin
      if (frame_cnt == 16'hFFFF) begin
        wrapped = 1'b1;
        break;
      end
      tick();
    end
    check("wrap_reached_ffff", {31'b0, wrapped}, 32'd1);
    tick();
    check("wrap_to_zero", {16'b0, frame_cnt}, 32'd0);
    ctrl_en = 1'b0;
    tick();
    check("wrap_final_frame_cnt", {16'b0, frame_cnt}, 32'd1);
    check("wrap_final_active", {31'b0, active}, 32'd0);
    sb_on = 1'b1;

    check("final_sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
